// File: rtl/tc_responder.sv
// ---------------------------------------------------------------------------
// tc_responder
//
// Memory-mapped timer/counter peripheral sitting behind the CPU data bus.
// It accepts single-cycle stores from the M stage, answers reads
// combinationally in the same cycle, and never stalls the pipeline.
// A four-state FSM (IDLE -> LOAD -> CNT -> INT) runs a 32-bit down-counter
// and raises an interrupt request when the count expires.
//
// Register map (word offset on i_addr):
//   0 CTRL   : [0] Enable, [2:1] Mode, [3] IM (interrupt mask), rest read 0
//   1 PRESET : 32-bit read/write reload value
//   2 COUNT  : 32-bit read-only current count
//   3 unused : reads 0, writes ignored
//
// Parameter:
//   DIV      : prescale divisor, COUNT decrements once every DIV cycles
//              spent counting (legal range 1..256)
//
// Ports:
//   i_clk    : system clock, all state changes on the rising edge
//   i_rst_n  : synchronous active-low reset
//   i_addr   : word offset (byte address bits [3:2])
//   i_we     : write strobe, one cycle per store, already address-qualified
//   i_din    : store data
//   o_dout   : read data, combinational from i_addr
//   o_irq    : interrupt request (internal flag gated by IM)
//
// Build option:
//   TC_AUTORELOAD_EN : when defined, Mode=1 auto-reloads the counter and
//                      produces a one-cycle irq pulse. When undefined,
//                      Mode=1 behaves like Mode 0 (Enable clears, sticky irq).
// ---------------------------------------------------------------------------
module tc_responder #(
  parameter int DIV = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [1:0]  i_addr,
  input  logic        i_we,
  input  logic [31:0] i_din,
  output logic [31:0] o_dout,
  output logic        o_irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  // Prescaler only needs to reach DIV-1; keep at least one bit for DIV=1.
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  state_t        r_state;
  state_t        w_state_next;

  logic          r_enable;
  logic [1:0]    r_mode;
  logic          r_im;
  logic [31:0]   r_preset;
  logic [31:0]   r_count;
  logic [PW-1:0] r_prescale;
  logic          r_irq;

  logic          w_ctrl_wr;
  logic          w_preset_wr;
  logic          w_tick;
  logic          w_count_le1;
  logic          w_reload;

  assign w_ctrl_wr   = i_we && (i_addr == 2'd0);
  assign w_preset_wr = i_we && (i_addr == 2'd1);
  assign w_tick      = (r_prescale == LAST);
  assign w_count_le1 = (r_count <= 32'd1);

  // Auto-reload is the only thing Mode=1 changes; without the option it
  // collapses onto the Mode 0 behaviour while CTRL still stores the bits.
`ifdef TC_AUTORELOAD_EN
  assign w_reload = (r_mode == 2'd1);
`else
  assign w_reload = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic. CNT leaves for IDLE as soon as Enable reads 0, so a
  // CTRL write clearing Enable lands on one edge and the FSM follows on the
  // next. INT always lasts exactly one cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_enable) begin
          w_state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        w_state_next = S_CNT;
      end
      S_CNT: begin
        if (!r_enable) begin
          w_state_next = S_IDLE;
        end else if (w_tick && w_count_le1) begin
          w_state_next = S_INT;
        end
      end
      S_INT: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // CTRL and PRESET. The INT-state Enable clear is assigned first so that a
  // bus write to CTRL in the same cycle overrides it and its Enable sticks.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_enable <= 1'b0;
      r_mode   <= 2'd0;
      r_im     <= 1'b0;
      r_preset <= 32'd0;
    end else begin
      if ((r_state == S_INT) && !w_reload) begin
        r_enable <= 1'b0;
      end
      if (w_ctrl_wr) begin
        r_enable <= i_din[0];
        r_mode   <= i_din[2:1];
        r_im     <= i_din[3];
      end
      if (w_preset_wr) begin
        r_preset <= i_din;
      end
    end
  end

  // COUNT and prescaler. LOAD samples the registered PRESET, so a PRESET
  // store landing on the same edge only affects the following reload.
  // The count saturates at 0 rather than wrapping.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count    <= 32'd0;
      r_prescale <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_count    <= r_preset;
          r_prescale <= '0;
        end
        S_CNT: begin
          if (r_enable) begin
            if (w_tick) begin
              r_prescale <= '0;
              r_count    <= w_count_le1 ? 32'd0 : (r_count - 32'd1);
            end else begin
              r_prescale <= r_prescale + PW'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Interrupt flag. In auto-reload mode it lives only for the INT cycle;
  // otherwise it is sticky until software touches CTRL or PRESET. Setting
  // on entry to INT is assigned last so it wins over a coincident write.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_irq <= 1'b0;
    end else begin
      if ((r_state == S_INT) && w_reload) begin
        r_irq <= 1'b0;
      end else if (w_ctrl_wr || w_preset_wr) begin
        r_irq <= 1'b0;
      end
      if ((r_state == S_CNT) && (w_state_next == S_INT)) begin
        r_irq <= 1'b1;
      end
    end
  end

  // Zero-latency read mux.
  always_comb begin
    o_dout = 32'd0;
    case (i_addr)
      2'd0:    o_dout = {28'd0, r_im, r_mode, r_enable};
      2'd1:    o_dout = r_preset;
      2'd2:    o_dout = r_count;
      default: o_dout = 32'd0;
    endcase
  end

  assign o_irq = r_irq & r_im;

endmodule

// File: tb/tb_tc_responder.sv
// ---------------------------------------------------------------------------
// tb_tc_responder
//
// Self-checking bench for tc_responder. Two instances share the bus: one
// built with DIV=1 for most scenarios and one with DIV=4 for the prescaler
// scenario. Expected values are queued when stimulus is driven and popped
// when the corresponding DUT output is sampled, one clock after the edge.
// ---------------------------------------------------------------------------
module tb_tc_responder;

  logic        clk;
  logic        rstN;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout1;
  logic        irq1;
  logic [31:0] dout4;
  logic        irq4;

  int nChecks = 0;
  int nPassed = 0;

  logic [31:0] expQ[$];
  logic [31:0] expVal;
  logic [31:0] obs;

  tc_responder #(.DIV(1)) dut1 (
    .i_clk   (clk),
    .i_rst_n (rstN),
    .i_addr  (addr),
    .i_we    (we),
    .i_din   (din),
    .o_dout  (dout1),
    .o_irq   (irq1)
  );

  tc_responder #(.DIV(4)) dut4 (
    .i_clk   (clk),
    .i_rst_n (rstN),
    .i_addr  (addr),
    .i_we    (we),
    .i_din   (din),
    .o_dout  (dout4),
    .o_irq   (irq4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle store; returns 1 ns after the edge that performs it.
  task automatic busWrite(input logic [1:0] a, input logic [31:0] d);
    addr = a;
    din  = d;
    we   = 1'b1;
    @(posedge clk);
    #1;
    we   = 1'b0;
  endtask

  task automatic doReset();
    we   = 1'b0;
    rstN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b1;
  endtask

  task automatic test_reset();
    doReset();
    for (int a = 0; a < 4; a++) expQ.push_back(32'd0);
    for (int a = 0; a < 4; a++) begin
      addr = a[1:0];
      #1;
      expVal = expQ.pop_front();
      nChecks++;
      if (dout1 !== expVal) $display("[TB] FAIL reset_read%0d: got %h expected %h", a, dout1, expVal);
      else nPassed++;
    end
    nChecks++;
    if (irq1 !== 1'b0) $display("[TB] FAIL reset_irq: got %b expected 0", irq1);
    else nPassed++;

    // Register access: PRESET readback, COUNT/offset 3 ignore writes,
    // CTRL upper bits read zero.
    busWrite(2'd1, 32'hA5A5_1234);
    busWrite(2'd2, 32'hFFFF_FFFF);
    busWrite(2'd3, 32'hFFFF_FFFF);
    busWrite(2'd0, 32'hFFFF_FFF0);
    expQ.push_back(32'hA5A5_1234);
    expQ.push_back(32'd0);
    expQ.push_back(32'd0);
    expQ.push_back(32'd0);
    for (int a = 1; a < 5; a++) begin
      addr = a[1:0];
      #1;
      expVal = expQ.pop_front();
      nChecks++;
      if (dout1 !== expVal) $display("[TB] FAIL regaccess%0d: got %h expected %h", a % 4, dout1, expVal);
      else nPassed++;
    end
  endtask

  task automatic test_mode0();
    doReset();
    busWrite(2'd1, 32'd5);
    busWrite(2'd0, 32'h9);
    // E1 is LOAD (count still 0), then 5..1, INT at E7 with count 0.
    expQ.push_back(32'd0);
    for (int v = 5; v >= 1; v--) expQ.push_back(v);
    expQ.push_back(32'd0);
    addr = 2'd2;
    for (int e = 1; e <= 7; e++) begin
      tick();
      expVal = expQ.pop_front();
      nChecks++;
      if (dout1 !== expVal) $display("[TB] FAIL mode0_count_e%0d: got %0d expected %0d", e, dout1, expVal);
      else nPassed++;
      nChecks++;
      if (irq1 !== (e == 7)) $display("[TB] FAIL mode0_irq_e%0d: got %b expected %b", e, irq1, (e == 7));
      else nPassed++;
    end
    repeat (4) tick();
    addr = 2'd0;
    #1;
    nChecks++;
    if (dout1 !== 32'h8) $display("[TB] FAIL mode0_ctrl_after: got %h expected 8", dout1);
    else nPassed++;
    nChecks++;
    if (irq1 !== 1'b1) $display("[TB] FAIL mode0_irq_sticky: got %b expected 1", irq1);
    else nPassed++;
    busWrite(2'd0, 32'h8);
    nChecks++;
    if (irq1 !== 1'b0) $display("[TB] FAIL mode0_irq_cleared: got %b expected 0", irq1);
    else nPassed++;
  endtask

  task automatic test_mode1();
    doReset();
    busWrite(2'd1, 32'd3);
    busWrite(2'd0, 32'hB);
    for (int e = 1; e <= 18; e++) begin
`ifdef TC_AUTORELOAD_EN
      expQ.push_back({31'd0, (e == 5) || (e == 11) || (e == 17)});
`else
      expQ.push_back({31'd0, (e >= 5)});
`endif
    end
    for (int e = 1; e <= 18; e++) begin
      tick();
      expVal = expQ.pop_front();
      nChecks++;
      if (irq1 !== expVal[0]) $display("[TB] FAIL mode1_irq_e%0d: got %b expected %b", e, irq1, expVal[0]);
      else nPassed++;
    end
    addr = 2'd0;
    #1;
`ifdef TC_AUTORELOAD_EN
    expVal = 32'hB;
`else
    expVal = 32'hA;
`endif
    nChecks++;
    if (dout1 !== expVal) $display("[TB] FAIL mode1_ctrl: got %h expected %h", dout1, expVal);
    else nPassed++;
  endtask

  task automatic test_preset_zero();
    doReset();
    busWrite(2'd1, 32'd0);
    busWrite(2'd0, 32'h9);
    addr = 2'd2;
    for (int e = 1; e <= 4; e++) begin
      tick();
      nChecks++;
      if (dout1 !== 32'd0) $display("[TB] FAIL pz_count_e%0d: got %0d expected 0", e, dout1);
      else nPassed++;
      nChecks++;
      if (irq1 !== (e >= 3)) $display("[TB] FAIL pz_irq_e%0d: got %b expected %b", e, irq1, (e >= 3));
      else nPassed++;
    end
  endtask

  task automatic test_int_priority();
    // CTRL store on the edge leaving INT keeps Enable and restarts the count.
    doReset();
    busWrite(2'd1, 32'd0);
    busWrite(2'd0, 32'h9);
    repeat (3) tick();
    busWrite(2'd0, 32'h9);
    addr = 2'd0;
    #1;
    nChecks++;
    if (dout1 !== 32'h9) $display("[TB] FAIL prio_ctrl: got %h expected 9", dout1);
    else nPassed++;
    nChecks++;
    if (irq1 !== 1'b0) $display("[TB] FAIL prio_irq_cleared: got %b expected 0", irq1);
    else nPassed++;
    repeat (3) tick();
    nChecks++;
    if (irq1 !== 1'b1) $display("[TB] FAIL prio_irq_again: got %b expected 1", irq1);
    else nPassed++;
  endtask

  task automatic test_div4();
    doReset();
    busWrite(2'd1, 32'd2);
    busWrite(2'd0, 32'h1);
    // CNT entered at E2; ticks every 4 cycles: count 1 at E6, INT at E10.
    for (int e = 1; e <= 12; e++) begin
      if (e < 2)       expQ.push_back(32'd0);
      else if (e < 6)  expQ.push_back(32'd2);
      else if (e < 10) expQ.push_back(32'd1);
      else             expQ.push_back(32'd0);
    end
    addr = 2'd2;
    for (int e = 1; e <= 12; e++) begin
      tick();
      expVal = expQ.pop_front();
      nChecks++;
      if (dout4 !== expVal) $display("[TB] FAIL div4_count_e%0d: got %0d expected %0d", e, dout4, expVal);
      else nPassed++;
      nChecks++;
      if (irq4 !== 1'b0) $display("[TB] FAIL div4_irq_masked_e%0d: got %b expected 0", e, irq4);
      else nPassed++;
    end
    addr = 2'd0;
    #1;
    nChecks++;
    if (dout4 !== 32'h0) $display("[TB] FAIL div4_ctrl_cleared: got %h expected 0", dout4);
    else nPassed++;
    busWrite(2'd0, 32'h8);
    repeat (6) tick();
    nChecks++;
    if (irq4 !== 1'b0) $display("[TB] FAIL div4_irq_after_unmask: got %b expected 0", irq4);
    else nPassed++;
    addr = 2'd2;
    #1;
    nChecks++;
    if (dout4 !== 32'd0) $display("[TB] FAIL div4_no_recount: got %0d expected 0", dout4);
    else nPassed++;
  endtask

  task automatic test_midcount_disable();
    logic [31:0] frozen;
    doReset();
    busWrite(2'd1, 32'd100);
    busWrite(2'd0, 32'h9);
    repeat (52) tick();
    addr = 2'd2;
    #1;
    nChecks++;
    if (dout1 !== 32'd50) $display("[TB] FAIL mid_count50: got %0d expected 50", dout1);
    else nPassed++;
    busWrite(2'd0, 32'h8);
    addr = 2'd2;
    #1;
    frozen = dout1;
    nChecks++;
    if (frozen !== 32'd49 && frozen !== 32'd50) $display("[TB] FAIL mid_freeze_value: got %0d expected 49 or 50", frozen);
    else nPassed++;
    repeat (5) tick();
    expQ.push_back(frozen);
    obs = dout1;
    expVal = expQ.pop_front();
    nChecks++;
    if (obs !== expVal) $display("[TB] FAIL mid_freeze_hold: got %0d expected %0d", obs, expVal);
    else nPassed++;
    nChecks++;
    if (irq1 !== 1'b0) $display("[TB] FAIL mid_disable_irq: got %b expected 0", irq1);
    else nPassed++;
    // Re-enable: must pass through LOAD, proving the FSM sat in IDLE.
    busWrite(2'd0, 32'h9);
    addr = 2'd2;
    tick();
    nChecks++;
    if (dout1 !== 32'd49 && dout1 !== 32'd50) $display("[TB] FAIL mid_load_cycle: got %0d expected 49 or 50", dout1);
    else nPassed++;
    tick();
    nChecks++;
    if (dout1 !== 32'd100) $display("[TB] FAIL mid_reload: got %0d expected 100", dout1);
    else nPassed++;
  endtask

  task automatic test_midcount_reset();
    logic sawIrq;
    doReset();
    busWrite(2'd1, 32'd100);
    busWrite(2'd0, 32'h9);
    repeat (52) tick();
    addr = 2'd2;
    #1;
    nChecks++;
    if (dout1 !== 32'd50) $display("[TB] FAIL rst_count50: got %0d expected 50", dout1);
    else nPassed++;
    rstN = 1'b0;
    @(posedge clk);
    #1;
    rstN = 1'b1;
    for (int a = 0; a < 3; a++) begin
      addr = a[1:0];
      #1;
      nChecks++;
      if (dout1 !== 32'd0) $display("[TB] FAIL rst_mid_read%0d: got %h expected 0", a, dout1);
      else nPassed++;
    end
    sawIrq = 1'b0;
    addr = 2'd2;
    for (int e = 0; e < 120; e++) begin
      tick();
      if (irq1 !== 1'b0) sawIrq = 1'b1;
    end
    nChecks++;
    if (sawIrq !== 1'b0) $display("[TB] FAIL rst_mid_no_irq: got %b expected 0", sawIrq);
    else nPassed++;
    nChecks++;
    if (dout1 !== 32'd0) $display("[TB] FAIL rst_mid_count_idle: got %0d expected 0", dout1);
    else nPassed++;
  endtask

  initial begin
    rstN = 1'b0;
    we   = 1'b0;
    addr = 2'd0;
    din  = 32'd0;
    test_reset();
    test_mode0();
    test_mode1();
    test_preset_zero();
    test_int_priority();
    test_div4();
    test_midcount_disable();
    test_midcount_reset();
    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule
